// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/UART sequencer: state encoding, ALU opcodes and flag indices.
// The ALU_FLAGS_TX_EN macro adds the two flag-transmit states.
package alu_pkg;

    localparam int STATE_W = 3;
    localparam int FLAGS_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_A   = 3'd0,
        ST_WAIT_B   = 3'd1,
        ST_WAIT_OP  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SEND_RES = 3'd4,
        ST_WAIT_RES = 3'd5
`ifdef ALU_FLAGS_TX_EN
        ,
        ST_SEND_FLG = 3'd6,
        ST_WAIT_FLG = 3'd7
`endif
    } state_e;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_OR  = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;
    localparam logic [3:0] OP_SRA = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0010;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_EXC   = 4;

    // Only the three operand-collection states may accept a received byte.
    function automatic logic rx_accepted(input state_e s);
        return (s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// UART-side byte handshake between the sequencer (master) and the UART RX/TX pair (slave).
interface alu_uart_ctrl_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  tx_done;
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_start;

    modport master (
        input  rx_data,
        input  rx_done,
        input  tx_done,
        output tx_data,
        output tx_start
    );

    modport slave (
        output rx_data,
        output rx_done,
        output tx_done,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Sequencer: collects operand A, operand B and opcode bytes from UART RX, drives the ALU,
// and returns the result (plus a flags byte when ALU_FLAGS_TX_EN is defined) through UART TX.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    alu_uart_ctrl_if.master         uart_if,
    input  logic [WORD_WIDTH-1:0]   i_alu_result,
    input  logic [FLAGS_W-1:0]      i_alu_flags,
    output logic [WORD_WIDTH-1:0]   o_operandA,
    output logic [WORD_WIDTH-1:0]   o_operandB,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic                    o_busy,
    output logic                    o_overrun
);

    state_e                  state_q;
    logic [WORD_WIDTH-1:0]   opa_q;
    logic [WORD_WIDTH-1:0]   opb_q;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [WORD_WIDTH-1:0]   tx_data_q;
    logic                    tx_start_q;
    logic                    busy_q;
    logic                    overrun_q;

`ifdef ALU_FLAGS_TX_EN
    logic [FLAGS_W-1:0]      flags_q;
`else
    logic                    unused_flags;
    assign unused_flags = ^i_alu_flags;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            opa_q      <= '0;
            opb_q      <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef ALU_FLAGS_TX_EN
            flags_q    <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            if (uart_if.rx_done && !rx_accepted(state_q)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_WAIT_A: if (uart_if.rx_done) begin
                    opa_q   <= uart_if.rx_data;
                    busy_q  <= 1'b1;
                    state_q <= ST_WAIT_B;
                end
                ST_WAIT_B: if (uart_if.rx_done) begin
                    opb_q   <= uart_if.rx_data;
                    state_q <= ST_WAIT_OP;
                end
                ST_WAIT_OP: if (uart_if.rx_done) begin
                    opcode_q <= uart_if.rx_data[OPCODE_WIDTH-1:0];
                    state_q  <= ST_EXEC;
                end
                // The ALU has had a full cycle to settle on the registered operands.
                ST_EXEC: begin
                    tx_data_q <= i_alu_result;
`ifdef ALU_FLAGS_TX_EN
                    flags_q   <= i_alu_flags;
`endif
                    state_q   <= ST_SEND_RES;
                end
                ST_SEND_RES: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_RES;
                end
                ST_WAIT_RES: if (uart_if.tx_done) begin
`ifdef ALU_FLAGS_TX_EN
                    tx_data_q <= {{(WORD_WIDTH-FLAGS_W){1'b0}}, flags_q};
                    state_q   <= ST_SEND_FLG;
`else
                    busy_q    <= 1'b0;
                    state_q   <= ST_WAIT_A;
`endif
                end
`ifdef ALU_FLAGS_TX_EN
                ST_SEND_FLG: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_FLG;
                end
                ST_WAIT_FLG: if (uart_if.tx_done) begin
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_A;
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign o_operandA       = opa_q;
    assign o_operandB       = opb_q;
    assign o_opcode         = opcode_q;
    assign o_busy           = busy_q;
    assign o_overrun        = overrun_q;
    assign uart_if.tx_data  = tx_data_q;
    assign uart_if.tx_start = tx_start_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Randomized self-checking bench for alu_uart_ctrl against a transaction-level reference;
// follows the ALU_FLAGS_TX_EN build option of the design.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int OW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_uart_ctrl_if #(.WORD_WIDTH(W)) uif ();

    logic [W-1:0]  alu_result;
    logic [4:0]    alu_flags;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [OW-1:0] opc;
    logic          busy;
    logic          ovr;
    logic [12:0]   alu_out;

    int checks   = 0;
    int failures = 0;
    bit exp_ovr  = 1'b0;

    alu_uart_ctrl #(.WORD_WIDTH(W), .OPCODE_WIDTH(OW)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .uart_if      (uif),
        .i_alu_result (alu_result),
        .i_alu_flags  (alu_flags),
        .o_operandA   (opA),
        .o_operandB   (opB),
        .o_opcode     (opc),
        .o_busy       (busy),
        .o_overrun    (ovr)
    );

    // Behavioural ALU: returns {exc, neg, ovf, carry, zero, result}.
    function automatic logic [12:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v, e;
        s = '0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SRA:  r = $unsigned($signed(a) >>> b[2:0]);
            OP_SRL:  r = a >> b[2:0];
            default: e = 1'b1;
        endcase
        return {e, r[7], v, c, (r == 8'd0), r};
    endfunction

    always_comb begin
        alu_out    = alu_ref(opA, opB, opc);
        alu_result = alu_out[7:0];
        alu_flags  = alu_out[12:8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uif.rx_data = b;
        uif.rx_done = 1'b1;
        @(negedge clk);
        uif.rx_done = 1'b0;
        uif.rx_data = 8'($urandom);
    endtask

    task automatic pulse_tx_done(input bit with_rx);
        uif.tx_done = 1'b1;
        if (with_rx) begin
            uif.rx_done = 1'b1;
            uif.rx_data = 8'($urandom);
        end
        @(negedge clk);
        uif.tx_done = 1'b0;
        uif.rx_done = 1'b0;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_tx_done(1'b0);
            else @(negedge clk);
        end
    endtask

    // mode: 0 clean, 1 stray rx byte during EXEC, 2 stray rx byte while waiting for tx_done.
    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int mode, input bit coincide);
        logic [12:0] rv;
        logic [7:0]  r;
        logic [4:0]  f;
        rv = alu_ref(a, b, opb[3:0]);
        r  = rv[7:0];
        f  = rv[12:8];
        idle_gap();
        send_byte(a);
        check("operandA", opA, a);
        check("busy_collect", busy, 1);
        idle_gap();
        send_byte(b);
        check("operandB", opB, b);
        idle_gap();
        send_byte(opb);
        check("opcode", opc, opb[3:0]);
        if (mode == 1) begin
            send_byte(8'h5A);
            exp_ovr = 1'b1;
        end else begin
            @(negedge clk);
        end
        check("start_early", uif.tx_start, 0);
        @(negedge clk);
        check("start_res", uif.tx_start, 1);
        check("tx_result", uif.tx_data, r);
        if (mode == 2) begin
            send_byte(8'($urandom));
            exp_ovr = 1'b1;
            check("ovr_set", ovr, 1);
            check("opA_kept", opA, a);
            check("opB_kept", opB, b);
        end else begin
            @(negedge clk);
        end
        check("start_single", uif.tx_start, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("tx_hold", uif.tx_data, r);
        if (coincide) exp_ovr = 1'b1;
        pulse_tx_done(coincide);
`ifdef ALU_FLAGS_TX_EN
        check("flg_early", uif.tx_start, 0);
        check("busy_flg", busy, 1);
        @(negedge clk);
        check("start_flg", uif.tx_start, 1);
        check("tx_flags", uif.tx_data, {3'b000, f});
        repeat ($urandom_range(1, 3)) @(negedge clk);
        pulse_tx_done(1'b0);
`else
        if (f[4]) check("exc_result_sent", uif.tx_data, r);
`endif
        check("busy_end", busy, 0);
        check("overrun", ovr, exp_ovr);
        check("opA_end", opA, a);
        check("opB_end", opB, b);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops [8];
        logic [7:0] a, b, opb;
        int mode;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, 4'b0000};
        uif.rx_data = '0;
        uif.rx_done = 1'b0;
        uif.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_opA", opA, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_start", uif.tx_start, 0);
        check("rst_txdata", uif.tx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(8'h05, 8'h03, 8'h08, 0, 1'b0);
        check("add_res", uif.tx_data, 8'h08);
        run_seq(8'h03, 8'h05, 8'hFA, 0, 1'b0);
        check("sub_opcode", opc, 4'hA);
        run_seq(8'h7F, 8'h01, 8'h08, 0, 1'b0);

        send_byte(8'h10);
        send_byte(8'h20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ovr = 1'b0;
        check("midrst_opA", opA, 0);
        check("midrst_opB", opB, 0);
        check("midrst_opc", opc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovr", ovr, 0);
        check("midrst_tx", uif.tx_data, 0);
        run_seq(8'h01, 8'h02, 8'h0D, 0, 1'b0);
        check("or_res", uif.tx_data, 8'h03);

        run_seq(8'h44, 8'h22, 8'h0E, 0, 1'b1);
        run_seq(8'hA5, 8'h0F, 8'h0C, 2, 1'b0);
        run_seq(8'h80, 8'h02, 8'h03, 0, 1'b0);
        run_seq(8'h12, 8'h34, 8'hF7, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            opb = {4'($urandom), ops[$urandom_range(0, 7)]};
            if ($urandom_range(0, 4) == 0) opb = 8'($urandom);
            mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_seq(a, b, opb, mode, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
